// File: rtl/pipe_pkg.sv
// Shared definitions for the MEM-stage memory access controller.
package pipe_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    MC_IDLE = 2'b00,
    MC_BUSY = 2'b01,
    MC_DONE = 2'b10
  } mc_state_e;

  // Load result reported when an access is abandoned.
  localparam logic [WORD_W-1:0] TIMEOUT_FILL = 32'h0;

endpackage

// File: rtl/pipe_wait_timer.sv
// Wait-cycle counter for an outstanding memory access; flags the last permitted cycle.
module pipe_wait_timer #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 8
) (
  input  logic clock,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_WAIT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/pipe_mem_ctrl.sv
// MEM-stage controller: runs each load/store as a req/ack transaction and
// freezes the upstream pipeline until the data memory completes or times out.
module pipe_mem_ctrl
  import pipe_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 8
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              mm2reg,
  input  logic              mwmem,
  input  logic [WORD_W-1:0] mAlu,
  input  logic [WORD_W-1:0] mb,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic [WORD_W-1:0] mmo,
  output logic              stall,
  output logic              wb_bubble,
  output logic              timeout_err
);

  mc_state_e state;
  logic      access;
  logic      expired;
  logic      hold;

  assign access = mm2reg | mwmem;

  pipe_wait_timer #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) u_timer (
    .clock   (clock),
    .resetn  (resetn),
    .clear   (state != MC_BUSY),
    .enable  ((state == MC_BUSY) && !mem_ack),
    .expired (expired)
  );

  always_comb begin
    hold = 1'b0;
    case (state)
      MC_IDLE: hold = access;
      MC_BUSY: hold = 1'b1;
      default: hold = 1'b0;
    endcase
  end

  // The reset gate keeps the pipeline free-running while reset is held.
  assign stall     = resetn & hold;
  assign wb_bubble = resetn & hold;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= MC_IDLE;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mmo         <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        MC_IDLE: begin
          if (access) begin
            mem_addr  <= mAlu;
            mem_wdata <= mb;
            mem_we    <= mwmem & ~mm2reg;
            mem_req   <= 1'b1;
            state     <= MC_BUSY;
          end
        end
        MC_BUSY: begin
          // mem_we is held for the whole access, so it tells load from store here.
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (!mem_we) mmo <= mem_rdata;
            state   <= MC_DONE;
          end else if (expired) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            timeout_err <= 1'b1;
            if (!mem_we) mmo <= TIMEOUT_FILL;
            state       <= MC_DONE;
          end
        end
        MC_DONE: begin
          state <= MC_IDLE;
        end
        default: begin
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          state   <= MC_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_mem_ctrl.sv
// Directed-vector bench for pipe_mem_ctrl: one task per scenario, inline checks.
module tb_pipe_mem_ctrl;

  logic        clock = 1'b0;
  logic        resetn;
  logic        mm2reg;
  logic        mwmem;
  logic [31:0] mAlu;
  logic [31:0] mb;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mmo;
  logic        stall;
  logic        wb_bubble;
  logic        timeout_err;

  int checks   = 0;
  int failures = 0;

  pipe_mem_ctrl #(.MAX_WAIT(15), .CNT_W(8)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .mm2reg      (mm2reg),
    .mwmem       (mwmem),
    .mAlu        (mAlu),
    .mb          (mb),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mmo         (mmo),
    .stall       (stall),
    .wb_bubble   (wb_bubble),
    .timeout_err (timeout_err)
  );

  always #5 clock = ~clock;

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; mm2reg = 1'b1; mwmem = 1'b0; mAlu = 32'h0; mb = 32'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    @(negedge clock);
    checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 ||
        mmo !== 32'h0 || timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: req=%b we=%b addr=%h wdata=%h mmo=%h terr=%b, expected all zero",
               mem_req, mem_we, mem_addr, mem_wdata, mmo, timeout_err);
    end
    checks++;
    if (stall !== 1'b0 || wb_bubble !== 1'b0) begin
      failures++;
      $display("FAIL reset_stall: stall=%b wb_bubble=%b, expected 0 0", stall, wb_bubble);
    end
    mm2reg = 1'b0;
    next_cycle();
    resetn = 1'b1;
    next_cycle();
  endtask

  task automatic test_load();
    int stall_cnt = 0;
    int req_cnt   = 0;
    mm2reg = 1'b1; mwmem = 1'b0; mAlu = 32'h0000_0010; mb = 32'h0;
    for (int c = 0; c < 6; c++) begin
      mem_ack   = (c == 1);
      mem_rdata = (c == 1) ? 32'hCAFE_F00D : 32'hDEAD_BEEF;
      if (c == 2) mm2reg = 1'b0;
      @(negedge clock);
      if (stall) stall_cnt++;
      if (mem_req) req_cnt++;
      if (c == 0) begin
        checks++;
        if (wb_bubble !== 1'b1) begin
          failures++;
          $display("FAIL load_bubble_detect: wb_bubble=%b, expected 1", wb_bubble);
        end
      end
      if (c == 1) begin
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h10 || mem_we !== 1'b0) begin
          failures++;
          $display("FAIL load_request: req=%b addr=%h we=%b, expected 1 00000010 0",
                   mem_req, mem_addr, mem_we);
        end
      end
      if (c == 2) begin
        checks++;
        if (mmo !== 32'hCAFE_F00D || stall !== 1'b0 || wb_bubble !== 1'b0) begin
          failures++;
          $display("FAIL load_done: mmo=%h stall=%b bubble=%b, expected cafef00d 0 0",
                   mmo, stall, wb_bubble);
        end
      end
      next_cycle();
    end
    mem_ack = 1'b0;
    checks++;
    if (stall_cnt != 2 || req_cnt != 1) begin
      failures++;
      $display("FAIL load_latency: stall_cycles=%0d req_cycles=%0d, expected 2 1", stall_cnt, req_cnt);
    end
  endtask

  task automatic test_store();
    int stall_cnt = 0;
    int wr_cnt    = 0;
    mm2reg = 1'b0; mwmem = 1'b1; mAlu = 32'h0000_0020; mb = 32'h1234_5678;
    for (int c = 0; c < 8; c++) begin
      mem_ack   = (c == 4);
      mem_rdata = 32'hBAD0_BAD0;
      if (c == 5) mwmem = 1'b0;
      @(negedge clock);
      if (stall) stall_cnt++;
      if (mem_req && mem_we === 1'b1 && mem_wdata === 32'h1234_5678 && mem_addr === 32'h20) wr_cnt++;
      if (c == 5) begin
        checks++;
        if (mmo !== 32'hCAFE_F00D || mem_req !== 1'b0) begin
          failures++;
          $display("FAIL store_done: mmo=%h req=%b, expected cafef00d 0", mmo, mem_req);
        end
      end
      next_cycle();
    end
    mem_ack = 1'b0;
    checks++;
    if (stall_cnt != 5 || wr_cnt != 4) begin
      failures++;
      $display("FAIL store_latency: stall_cycles=%0d write_cycles=%0d, expected 5 4", stall_cnt, wr_cnt);
    end
  endtask

  task automatic test_spurious_ack();
    mm2reg = 1'b0; mwmem = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      checks++;
      if (stall !== 1'b0 || mem_req !== 1'b0 || mmo !== 32'hCAFE_F00D || timeout_err !== 1'b0) begin
        failures++;
        $display("FAIL spurious_ack: stall=%b req=%b mmo=%h terr=%b, expected 0 0 cafef00d 0",
                 stall, mem_req, mmo, timeout_err);
      end
      next_cycle();
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_timeout();
    int stall_cnt = 0;
    int req_cnt   = 0;
    mm2reg = 1'b1; mwmem = 1'b0; mAlu = 32'h0000_0030; mem_ack = 1'b0; mem_rdata = 32'h7777_7777;
    for (int c = 0; c < 20; c++) begin
      if (c == 16) mm2reg = 1'b0;
      @(negedge clock);
      if (stall) stall_cnt++;
      if (mem_req) req_cnt++;
      if (c == 15) begin
        checks++;
        if (timeout_err !== 1'b0 || mem_req !== 1'b1) begin
          failures++;
          $display("FAIL timeout_last_busy: terr=%b req=%b, expected 0 1", timeout_err, mem_req);
        end
      end
      if (c == 16) begin
        checks++;
        if (timeout_err !== 1'b1 || mmo !== 32'h0 || mem_req !== 1'b0 || stall !== 1'b0) begin
          failures++;
          $display("FAIL timeout_done: terr=%b mmo=%h req=%b stall=%b, expected 1 00000000 0 0",
                   timeout_err, mmo, mem_req, stall);
        end
      end
      next_cycle();
    end
    checks++;
    if (stall_cnt != 16 || req_cnt != 15) begin
      failures++;
      $display("FAIL timeout_latency: stall_cycles=%0d req_cycles=%0d, expected 16 15", stall_cnt, req_cnt);
    end
    checks++;
    if (timeout_err !== 1'b1) begin
      failures++;
      $display("FAIL timeout_sticky: terr=%b, expected 1", timeout_err);
    end
  endtask

  task automatic test_back_to_back();
    int  stall_cnt = 0;
    int  pulses    = 0;
    int  dones     = 0;
    logic prev_req = 1'b0;
    for (int c = 0; c < 8; c++) begin
      mm2reg    = (c <= 2);
      mwmem     = (c >= 3 && c <= 5);
      mAlu      = (c <= 2) ? 32'h40 : 32'h44;
      mb        = 32'h0000_0055;
      mem_ack   = (c == 1 || c == 4);
      mem_rdata = (c == 1) ? 32'h1111_2222 : 32'h9999_9999;
      @(negedge clock);
      if (stall) stall_cnt++;
      if (mem_req && !prev_req) pulses++;
      prev_req = mem_req;
      if ((mm2reg || mwmem) && !stall) dones++;
      if (c == 1) begin
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 1'b0) begin
          failures++;
          $display("FAIL b2b_load_req: req=%b addr=%h we=%b, expected 1 00000040 0",
                   mem_req, mem_addr, mem_we);
        end
      end
      if (c == 4) begin
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h44 || mem_we !== 1'b1 || mem_wdata !== 32'h55) begin
          failures++;
          $display("FAIL b2b_store_req: req=%b addr=%h we=%b wdata=%h, expected 1 00000044 1 00000055",
                   mem_req, mem_addr, mem_we, mem_wdata);
        end
      end
      if (c == 5) begin
        checks++;
        if (mmo !== 32'h1111_2222) begin
          failures++;
          $display("FAIL b2b_mmo: mmo=%h, expected 11112222", mmo);
        end
      end
      next_cycle();
    end
    mm2reg = 1'b0; mwmem = 1'b0; mem_ack = 1'b0;
    checks++;
    if (pulses != 2 || dones != 2 || stall_cnt != 4) begin
      failures++;
      $display("FAIL b2b_counts: req_pulses=%0d done_cycles=%0d stall_cycles=%0d, expected 2 2 4",
               pulses, dones, stall_cnt);
    end
  endtask

  task automatic test_reset_mid_access();
    mm2reg = 1'b1; mwmem = 1'b0; mAlu = 32'h50; mem_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      if (c == 2) begin
        checks++;
        if (mem_req !== 1'b1) begin
          failures++;
          $display("FAIL rst_mid_pre: req=%b, expected 1", mem_req);
        end
        #1 resetn = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 ||
            mmo !== 32'h0 || timeout_err !== 1'b0 || stall !== 1'b0 || wb_bubble !== 1'b0) begin
          failures++;
          $display("FAIL rst_mid_async: req=%b we=%b addr=%h wdata=%h mmo=%h terr=%b stall=%b bubble=%b, expected all zero",
                   mem_req, mem_we, mem_addr, mem_wdata, mmo, timeout_err, stall, wb_bubble);
        end
        mm2reg = 1'b0;
      end
      next_cycle();
    end
    resetn = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      checks++;
      if (stall !== 1'b0 || mem_req !== 1'b0 || mmo !== 32'h0) begin
        failures++;
        $display("FAIL rst_mid_after: stall=%b req=%b mmo=%h, expected 0 0 00000000", stall, mem_req, mmo);
      end
      next_cycle();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load();
    test_store();
    test_spurious_ack();
    test_timeout();
    test_back_to_back();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
